// File: rtl/hex_display_pkg.sv
// Shared constants and types for the hexadecimal 7-segment display driver.
// Segment bit order is a (MSB) through g (LSB); patterns are stored active-low.
package hex_display_pkg;

  localparam int SEG_WIDTH = 7;

  typedef logic [SEG_WIDTH-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Index n holds the active-low pattern for nibble n (listed F down to 0).
  localparam logic [15:0][SEG_WIDTH-1:0] SEG_HEX = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic seg_t seg_lookup(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/hex_digit_encoder.sv
// Combinational nibble to 7-segment encoder.
// Output polarity follows ACTIVE_LOW.
module hex_digit_encoder
  import hex_display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]           nibble,
  output logic [SEG_WIDTH-1:0] segs
);

  seg_t pattern_al;

  always_comb begin
    pattern_al = seg_lookup(nibble);
    segs       = ACTIVE_LOW ? pattern_al : ~pattern_al;
  end

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit hex display driver: latches a packed value, encodes each digit,
// applies leading-zero and blink blanking, and registers the segment outputs.
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            Load,
  input  logic [4*NUM_DIGITS-1:0]         Value,
  input  logic                            BlankLZ,
  input  logic [NUM_DIGITS-1:0]           BlinkMask,
  output logic [SEG_WIDTH*NUM_DIGITS-1:0] Segs,
  output logic                            BlinkPhase
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [SEG_WIDTH-1:0] BLANK_PAT = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  logic [4*NUM_DIGITS-1:0]         latch_q, latch_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            phase_q, phase_d;
  logic [SEG_WIDTH*NUM_DIGITS-1:0] segs_q, segs_d;

  logic                            wrap;
  logic [SEG_WIDTH-1:0]            enc [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]           all_zero;
  logic [NUM_DIGITS-1:0]           blank;

  always_comb begin
    latch_d = Load ? Value : latch_q;
  end

  always_comb begin
    wrap    = (cnt_q == CNT_LAST);
    cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
    phase_d = phase_q ^ wrap;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    hex_digit_encoder #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_enc (
      .nibble(latch_q[4*g +: 4]),
      .segs  (enc[g])
    );
  end

  // Walk from the most significant digit down, tracking "everything above and
  // including this digit is zero"; digit 0 is exempt so a zero value still shows.
  always_comb begin
    logic run;
    run      = 1'b1;
    all_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run         = run & (latch_q[4*i +: 4] == 4'h0);
      all_zero[i] = run;
    end
  end

  always_comb begin
    blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank[i] = (phase_q & BlinkMask[i]) | (BlankLZ & all_zero[i] & (i != 0));
    end
  end

  always_comb begin
    segs_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      segs_d[SEG_WIDTH*i +: SEG_WIDTH] = blank[i] ? BLANK_PAT : enc[i];
    end
  end

  // Reset takes priority over Load and blanks every digit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      latch_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      segs_q  <= {NUM_DIGITS{BLANK_PAT}};
    end else begin
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      segs_q  <= segs_d;
    end
  end

  assign Segs       = segs_q;
  assign BlinkPhase = phase_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Self-checking bench for hex_display_driver (4 digits, blink every 4 cycles,
// active-low) using directed steps followed by randomized traffic.
module tb_hex_display_driver;

  localparam int NUM_DIGITS = 4;
  localparam int BLINK_DIV  = 4;

  logic        Clk;
  logic        Reset;
  logic        Load;
  logic [15:0] Value;
  logic        BlankLZ;
  logic [3:0]  BlinkMask;
  logic [27:0] Segs;
  logic        BlinkPhase;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [15:0] mLatch;
  int          mEdges;
  logic        mPhase;
  logic [27:0] mSegs;

  hex_display_driver #(
    .NUM_DIGITS(NUM_DIGITS),
    .BLINK_DIV (BLINK_DIV),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .Value     (Value),
    .BlankLZ   (BlankLZ),
    .BlinkMask (BlinkMask),
    .Segs      (Segs),
    .BlinkPhase(BlinkPhase)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [6:0] segPat(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // A digit hides behind leading-zero blanking when the value shifted down to
  // that digit is zero; blink hides it when the phase is dark and its mask bit set.
  function automatic logic [27:0] modelSegs(input logic [15:0] latchVal, input logic phase,
                                            input logic blz, input logic [3:0] mask);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((blz && i != 0 && (latchVal >> (4 * i)) == 16'h0) || (phase && mask[i]))
        r[7*i +: 7] = 7'b1111111;
      else
        r[7*i +: 7] = segPat(latchVal[4*i +: 4]);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [27:0] expSegs, input logic expPhase);
    nCompared++;
    assert (Segs === expSegs) else begin
      nMismatched++;
      $error("[TB] FAIL %s segs: observed %07h expected %07h", tag, Segs, expSegs);
    end
    nCompared++;
    assert (BlinkPhase === expPhase) else begin
      nMismatched++;
      $error("[TB] FAIL %s phase: observed %0b expected %0b", tag, BlinkPhase, expPhase);
    end
  endtask

  task automatic checkSegs(input string tag, input logic [27:0] expSegs);
    nCompared++;
    assert (Segs === expSegs) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %07h expected %07h", tag, Segs, expSegs);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model across the edge,
  // then compare the DUT against it shortly after the edge.
  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v,
                               input logic blz, input logic [3:0] mask);
    @(negedge Clk);
    Reset     = r;
    Load      = l;
    Value     = v;
    BlankLZ   = blz;
    BlinkMask = mask;
    @(posedge Clk);
    if (r) begin
      mLatch = 16'h0;
      mEdges = 0;
      mSegs  = {4{7'b1111111}};
    end else begin
      mSegs  = modelSegs(mLatch, mPhase, blz, mask);
      if (l) mLatch = v;
      mEdges++;
    end
    mPhase = ((mEdges / BLINK_DIV) % 2) == 1;
    #1;
    checkOutput("cycle", mSegs, mPhase);
  endtask

  initial begin
    Reset     = 1'b1;
    Load      = 1'b0;
    Value     = 16'h0;
    BlankLZ   = 1'b0;
    BlinkMask = 4'h0;
    mLatch    = 16'h0;
    mEdges    = 0;
    mPhase    = 1'b0;
    mSegs     = '1;

    applyStimulus(1, 0, 16'h0, 0, 4'h0);
    applyStimulus(1, 0, 16'h0, 0, 4'h0);
    checkSegs("reset_blank", {4{7'b1111111}});

    applyStimulus(0, 0, 16'h0, 0, 4'h0);
    checkSegs("zeros_after_reset", {4{7'b0000001}});

    applyStimulus(0, 1, 16'h1A3F, 0, 4'h0);
    applyStimulus(0, 0, 16'h0, 0, 4'h0);
    checkSegs("load_1A3F", {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000});
    applyStimulus(0, 0, 16'hFFFF, 0, 4'h0);
    applyStimulus(0, 0, 16'h0, 0, 4'h0);
    checkSegs("hold_1A3F", {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000});

    applyStimulus(0, 1, 16'h0040, 1, 4'h0);
    applyStimulus(0, 0, 16'h0, 1, 4'h0);
    checkSegs("lz_0040", {7'b1111111, 7'b1111111, 7'b1001100, 7'b0000001});
    applyStimulus(0, 1, 16'h0000, 1, 4'h0);
    applyStimulus(0, 0, 16'h0, 1, 4'h0);
    checkSegs("lz_0000", {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001});

    applyStimulus(0, 1, 16'h8888, 0, 4'h1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 16'h0, 0, 4'h1);
      checkSegs("blink_upper", {{3{7'b0000000}}, Segs[6:0] == 7'b0000000 ? 7'b0000000 : 7'b1111111});
    end

    for (int g = 0; g < 8 && (mEdges % BLINK_DIV) != BLINK_DIV - 1; g++)
      applyStimulus(0, 0, 16'h0, 0, 4'h1);
    applyStimulus(0, 1, 16'h1234, 0, 4'h1);
    applyStimulus(0, 0, 16'h0, 0, 4'h1);
    applyStimulus(1, 1, 16'hBEEF, 0, 4'h1);
    checkSegs("reset_over_load", {4{7'b1111111}});
    applyStimulus(0, 0, 16'h0, 0, 4'h0);
    checkSegs("discarded_load", {4{7'b0000001}});

    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, 1, 16'(k), 0, 4'h0);
      if (k > 1) checkSegs("step_digit0", {{3{7'b0000001}}, segPat(4'(k - 1))});
    end
    applyStimulus(0, 0, 16'h0, 0, 4'h0);
    checkSegs("step_digit0_last", {{3{7'b0000001}}, segPat(4'h5)});

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(31) == 0), $urandom_range(1), 16'($urandom),
                    $urandom_range(1), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
